// File: rtl/sdram_refresh_sched.sv
// SDRAM command-bus sequencer: JEDEC power-up, periodic auto-refresh with a
// small refresh debt counter, and a req/gnt handoff of the bus to the datapath.
module sdram_refresh_sched #(
    parameter int          T_INIT_CYC = 20000,
    parameter int          T_RP       = 2,
    parameter int          T_RFC      = 7,
    parameter int          T_MRD      = 2,
    parameter int          REFI_CYC   = 780,
    parameter logic [12:0] MODE_REG   = 13'h030
) (
    input  logic        soc_clk,
    input  logic        soc_reset,
    input  logic        dp_req,
    output logic        dp_gnt,
    output logic        refresh_pend,
    output logic        init_done,
    output logic        ref_overflow,
    output logic        seq_owns,
    output logic        seq_cke,
    output logic [3:0]  seq_cmd,
    output logic [12:0] seq_addr,
    output logic [1:0]  seq_ba
);

    localparam logic [3:0] CMD_DESELECT = 4'b1111;
    localparam logic [3:0] CMD_NOP      = 4'b0111;
    localparam logic [3:0] CMD_PRE      = 4'b0010;
    localparam logic [3:0] CMD_REF      = 4'b0001;
    localparam logic [3:0] CMD_LMR      = 4'b0000;
    localparam logic [12:0] ADDR_ALL_BANKS = 13'h0400;

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
        S_IDLE, S_GRANT, S_PRE, S_REF
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] timer_reg, timer_next;
    logic [15:0] refi_cnt_reg, refi_cnt_next;
    logic [2:0]  debt_reg, debt_next, debt_eff;
    logic        ref_issued_reg, ref_issued_next;
    logic        init_done_reg, init_done_next;
    logic        ovf_reg, ovf_next;
    logic        pend_reg, gnt_reg, owns_reg, cke_reg;
    logic [3:0]  cmd_reg, cmd_next;
    logic [12:0] addr_reg, addr_next;
    logic [1:0]  ba_reg, ba_next;
    logic        timer_zero, expire;

    assign timer_zero = (timer_reg == 16'd0);
    // A refresh issued on the previous edge has not yet been subtracted.
    assign debt_eff   = debt_reg - {2'b00, ref_issued_reg};

    // Each transition into a command state issues that command on the same
    // edge and loads the timer so the next command lands exactly one gap later.
    always_comb begin
        state_next      = state_reg;
        timer_next      = timer_zero ? 16'd0 : timer_reg - 16'd1;
        cmd_next        = CMD_NOP;
        addr_next       = '0;
        ba_next         = '0;
        ref_issued_next = 1'b0;
        init_done_next  = init_done_reg;
        case (state_reg)
            S_INIT_WAIT: if (timer_zero) begin
                state_next = S_INIT_PRE;
                cmd_next   = CMD_PRE;
                addr_next  = ADDR_ALL_BANKS;
                timer_next = 16'(T_RP - 1);
            end
            S_INIT_PRE: if (timer_zero) begin
                state_next = S_INIT_REF1;
                cmd_next   = CMD_REF;
                timer_next = 16'(T_RFC - 1);
            end
            S_INIT_REF1: if (timer_zero) begin
                state_next = S_INIT_REF2;
                cmd_next   = CMD_REF;
                timer_next = 16'(T_RFC - 1);
            end
            S_INIT_REF2: if (timer_zero) begin
                state_next = S_INIT_MRS;
                cmd_next   = CMD_LMR;
                addr_next  = MODE_REG;
                timer_next = 16'(T_MRD - 1);
            end
            S_INIT_MRS: if (timer_zero) begin
                state_next     = S_IDLE;
                init_done_next = 1'b1;
            end
            S_IDLE: begin
                if (debt_reg != 3'd0 && !dp_req) begin
                    state_next = S_PRE;
                    cmd_next   = CMD_PRE;
                    addr_next  = ADDR_ALL_BANKS;
                    timer_next = 16'(T_RP - 1);
                end else if (dp_req && debt_reg == 3'd0) begin
                    state_next = S_GRANT;
                end
            end
            S_GRANT: if (!dp_req) state_next = S_IDLE;
            S_PRE: if (timer_zero) begin
                state_next      = S_REF;
                cmd_next        = CMD_REF;
                timer_next      = 16'(T_RFC - 1);
                ref_issued_next = 1'b1;
            end
            S_REF: if (timer_zero) begin
                if (debt_eff != 3'd0) begin
                    cmd_next        = CMD_REF;
                    timer_next      = 16'(T_RFC - 1);
                    ref_issued_next = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_INIT_WAIT;
        endcase
    end

    assign expire = init_done_reg && (refi_cnt_reg == 16'(REFI_CYC - 1));

    always_comb begin
        refi_cnt_next = (!init_done_reg || expire) ? 16'd0 : refi_cnt_reg + 16'd1;
        debt_next     = debt_reg;
        ovf_next      = ovf_reg;
        // Simultaneous expiry and refresh cancel; an expiry is only lost at 7.
        if (expire && !ref_issued_reg) begin
            if (debt_reg == 3'd7) ovf_next = 1'b1;
            else                  debt_next = debt_reg + 3'd1;
        end else if (ref_issued_reg && !expire) begin
            debt_next = debt_reg - 3'd1;
        end
    end

    always_ff @(posedge soc_clk) begin
        if (soc_reset) begin
            state_reg      <= S_INIT_WAIT;
            timer_reg      <= 16'(T_INIT_CYC);
            refi_cnt_reg   <= '0;
            debt_reg       <= '0;
            ref_issued_reg <= 1'b0;
            init_done_reg  <= 1'b0;
            ovf_reg        <= 1'b0;
            pend_reg       <= 1'b0;
            gnt_reg        <= 1'b0;
            owns_reg       <= 1'b1;
            cke_reg        <= 1'b0;
            cmd_reg        <= CMD_DESELECT;
            addr_reg       <= '0;
            ba_reg         <= '0;
        end else begin
            state_reg      <= state_next;
            timer_reg      <= timer_next;
            refi_cnt_reg   <= refi_cnt_next;
            debt_reg       <= debt_next;
            ref_issued_reg <= ref_issued_next;
            init_done_reg  <= init_done_next;
            ovf_reg        <= ovf_next;
            pend_reg       <= (debt_next != 3'd0);
            gnt_reg        <= (state_next == S_GRANT);
            owns_reg       <= (state_next != S_GRANT);
            cke_reg        <= 1'b1;
            cmd_reg        <= cmd_next;
            addr_reg       <= addr_next;
            ba_reg         <= ba_next;
        end
    end

    assign dp_gnt       = gnt_reg;
    assign refresh_pend = pend_reg;
    assign init_done    = init_done_reg;
    assign ref_overflow = ovf_reg;
    assign seq_owns     = owns_reg;
    assign seq_cke      = cke_reg;
    assign seq_cmd      = cmd_reg;
    assign seq_addr     = addr_reg;
    assign seq_ba       = ba_reg;

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Scoreboard bench for sdram_refresh_sched: an event-time reference model
// pushes expected outputs per edge, a negedge monitor pops and compares.
module tb_sdram_refresh_sched;

    localparam int TI = 10, RP = 2, RFC = 4, MRD = 2, REFI = 50;
    localparam int T_PRE  = TI;
    localparam int T_R1   = T_PRE + RP;
    localparam int T_R2   = T_R1 + RFC;
    localparam int T_MRS  = T_R2 + RFC;
    localparam int T_DONE = T_MRS + MRD;
    localparam int WATCHDOG_T = 200000;

    localparam logic [3:0] C_DES = 4'b1111, C_NOP = 4'b0111, C_PRE = 4'b0010,
                           C_REF = 4'b0001, C_LMR = 4'b0000;

    typedef struct packed {
        logic        gnt;
        logic        owns;
        logic        pend;
        logic        done;
        logic        ovf;
        logic        cke;
        logic [3:0]  cmd;
        logic [12:0] addr;
        logic [1:0]  ba;
    } obs_t;

    typedef struct {
        int   seg;
        int   cyc;
        obs_t val;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   finished = 0;

    logic        soc_clk = 1'b0;
    logic        soc_reset = 1'b1;
    logic        dp_req = 1'b0;
    logic        dp_gnt, refresh_pend, init_done, ref_overflow, seq_owns, seq_cke;
    logic [3:0]  seq_cmd;
    logic [12:0] seq_addr;
    logic [1:0]  seq_ba;
    obs_t        act;

    sdram_refresh_sched #(
        .T_INIT_CYC(TI), .T_RP(RP), .T_RFC(RFC), .T_MRD(MRD),
        .REFI_CYC(REFI), .MODE_REG(13'h030)
    ) dut (
        .soc_clk(soc_clk), .soc_reset(soc_reset), .dp_req(dp_req),
        .dp_gnt(dp_gnt), .refresh_pend(refresh_pend), .init_done(init_done),
        .ref_overflow(ref_overflow), .seq_owns(seq_owns), .seq_cke(seq_cke),
        .seq_cmd(seq_cmd), .seq_addr(seq_addr), .seq_ba(seq_ba)
    );

    always #5 soc_clk = ~soc_clk;

    assign act = {dp_gnt, seq_owns, refresh_pend, init_done, ref_overflow,
                  seq_cke, seq_cmd, seq_addr, seq_ba};

    always @(negedge soc_clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            if (act !== mon_e.val) begin
                n_bad++;
                $display("FAIL outputs seg=%0d cyc=%0d got gnt=%b owns=%b pend=%b done=%b ovf=%b cke=%b cmd=%b addr=%h ba=%0d expected gnt=%b owns=%b pend=%b done=%b ovf=%b cke=%b cmd=%b addr=%h ba=%0d",
                         mon_e.seg, mon_e.cyc, act.gnt, act.owns, act.pend, act.done,
                         act.ovf, act.cke, act.cmd, act.addr, act.ba,
                         mon_e.val.gnt, mon_e.val.owns, mon_e.val.pend, mon_e.val.done,
                         mon_e.val.ovf, mon_e.val.cke, mon_e.val.cmd, mon_e.val.addr,
                         mon_e.val.ba);
            end
        end
    end

    initial begin
        #(WATCHDOG_T);
        if (!finished) begin
            n_bad++;
            $display("FAIL watchdog expired after %0d time units with %0d expected entries pending",
                     WATCHDOG_T, exp_q.size());
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
            $finish;
        end
    end

    task automatic push(input int seg, input int cyc, input obs_t v);
        exp_t e;
        e.seg = seg;
        e.cyc = cyc;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input int seg, input int n);
        obs_t v;
        v = '{gnt: 1'b0, owns: 1'b1, pend: 1'b0, done: 1'b0, ovf: 1'b0,
              cke: 1'b0, cmd: C_DES, addr: 13'h0, ba: 2'd0};
        for (int i = 0; i < n; i++) begin
            soc_reset = 1'b1;
            dp_req    = 1'b0;
            @(posedge soc_clk);
            push(seg, -1, v);
            #1;
            n_cmp++;
            if (act !== v) begin
                n_bad++;
                $display("FAIL reset seg=%0d rst_cyc=%0d got gnt=%b owns=%b pend=%b done=%b ovf=%b cke=%b cmd=%b addr=%h ba=%0d",
                         seg, i, act.gnt, act.owns, act.pend, act.done, act.ovf,
                         act.cke, act.cmd, act.addr, act.ba);
            end
        end
    endtask

    // kind 0: dp_req low; kind 1: high for sampled cycles lo..hi; kind 2: random bursts.
    // The model tracks refresh work as absolute issue times rather than a timer.
    task automatic run_segment(input int seg, input int n, input int kind,
                               input int lo, input int hi);
        int   debt = 0;
        bit   ovf = 0, granted = 0, servicing = 0, first = 0;
        int   svc_t = 0, last_ref = -100, run_left = 0;
        bit   rnd_req = 0, req, dec, expiry;
        obs_t v;
        for (int k = 0; k < n; k++) begin
            case (kind)
                1:       req = (k >= lo && k <= hi);
                2: begin
                    if (run_left == 0) begin
                        rnd_req  = ~rnd_req;
                        run_left = int'($urandom_range(1, 60));
                    end
                    run_left--;
                    req = rnd_req;
                end
                default: req = 1'b0;
            endcase
            soc_reset = 1'b0;
            dp_req    = req;

            v = '{gnt: 1'b0, owns: 1'b1, pend: 1'b0, done: 1'b0, ovf: 1'b0,
                  cke: 1'b1, cmd: C_NOP, addr: 13'h0, ba: 2'd0};
            if (k <= T_DONE) begin
                if (k == T_PRE) begin
                    v.cmd = C_PRE; v.addr = 13'h400;
                end else if (k == T_R1 || k == T_R2) begin
                    v.cmd = C_REF;
                end else if (k == T_MRS) begin
                    v.cmd = C_LMR; v.addr = 13'h030;
                end
            end else begin
                dec    = (last_ref == k - 1);
                expiry = ((k - T_DONE) % REFI == 0);
                if (granted) begin
                    if (!req) granted = 0;
                end else if (servicing) begin
                    if (k == svc_t) begin
                        if (first || (debt - int'(dec)) > 0) begin
                            v.cmd = C_REF; last_ref = k; svc_t = k + RFC; first = 0;
                        end else begin
                            servicing = 0;
                        end
                    end
                end else if (debt > 0 && !req) begin
                    v.cmd = C_PRE; v.addr = 13'h400;
                    servicing = 1; first = 1; svc_t = k + RP;
                end else if (req && debt == 0) begin
                    granted = 1;
                end
                if (expiry && !dec) begin
                    if (debt == 7) ovf = 1;
                    else           debt++;
                end else if (dec && !expiry) begin
                    debt--;
                end
            end
            v.gnt  = granted;
            v.owns = !granted;
            v.pend = (debt != 0);
            v.done = (k >= T_DONE);
            v.ovf  = ovf;
            @(posedge soc_clk);
            push(seg, k, v);
            #1;
        end
    endtask

    initial begin
        do_reset(0, 3);
        run_segment(1, 77, 0, 0, 0);      // init, idle refresh, reset right after REFRESH
        do_reset(1, 2);
        run_segment(2, 140, 1, 31, 120);  // grant defers two refreshes
        do_reset(2, 2);
        run_segment(3, 130, 1, 75, 110);  // request during refresh waits
        do_reset(3, 2);
        run_segment(4, 580, 1, 31, 500);  // debt saturates, overflow sticks
        do_reset(4, 2);
        for (int s = 5; s < 8; s++) begin
            run_segment(s, int'($urandom_range(250, 400)), 2, 0, 0);
            do_reset(s, int'($urandom_range(1, 3)));
        end
        repeat (2) @(negedge soc_clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain %0d expected entries never compared", exp_q.size());
        end
        finished = 1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
